gbn_arq_tx: RTL
===============

GBN_ARQ_TX -- requirements
Module: gbn_arq_tx

Interface
REQ-001 Parameters SHALL be: DW, default 8, payload width; SEQ_W, default 3, sequence-number width; WIN, default 4, window depth, power of 2, WIN < 2**SEQ_W; TIMEOUT, default 16, retransmit timeout in cycles, >= 2.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  payload offered.
REQ-005 in_data  in  DW  payload.
REQ-006 in_ready  out  1  payload accepted on in_valid & in_ready.
REQ-007 tx_valid  out  1  frame offered to channel.
REQ-008 tx_frame  out  SEQ_W+DW+4  {seq, payload, crc4}.
REQ-009 tx_ready  in  1  channel takes frame on tx_valid & tx_ready.
REQ-010 ack_valid  in  1  cumulative acknowledgement strobe.
REQ-011 ack_seq  in  SEQ_W  highest sequence number acknowledged.
REQ-012 win_count  out  $clog2(WIN+1)  frames buffered and unacknowledged.
REQ-013 retx_count  out  8  timeout events, saturating at 255.

Function
REQ-014 Pointers, all SEQ_W bits, modulo 2**SEQ_W: base (oldest unacked), snd (next to transmit), nxt (next new seq), hi (one past highest ever transmitted).
REQ-015 Buffer: WIN entries of DW bits, indexed by seq[$clog2(WIN)-1:0].
REQ-016 win_count = nxt - base; in_ready = (win_count < WIN), combinational.
REQ-017 Accepted payload written to buffer[nxt]; nxt increments at the same edge.
REQ-018 tx_valid = (snd != nxt); tx_frame = {snd, buffer[snd], crc4(buffer[snd])} when tx_valid, else all zeros; both combinational from registers.
REQ-019 crc4: polynomial x^4+x+1, init 0, payload MSB first, no reflection, no final XOR; crc4(8'hA5) = 4'hB.
REQ-020 On tx handshake: snd increments; hi = snd+1 if (snd+1 - base) > (hi - base), else hi unchanged.
REQ-021 Ack valid only if (ack_seq - base) < (hi - base); valid ack sets base = ack_seq+1 and, if snd lies behind the new base, sets snd = new base; invalid or duplicate ack has no effect.
REQ-022 Timer counts each cycle while hi != base; it clears on a valid ack, on a timeout and whenever hi == base.
REQ-023 Timeout when timer == TIMEOUT-1 and hi != base: snd = base at the next edge, timer = 0, retx_count increments unless already 255.
REQ-024 A tx handshake in the timeout cycle SHALL be counted in hi, but snd SHALL load base.
REQ-025 A valid ack in the timeout cycle SHALL take priority; the timeout is suppressed for that cycle.
REQ-026 Payload accept and valid ack in the same cycle SHALL both take effect; win_count = old + 1 - advance.
REQ-027 Frames are not required to hold stable while tx_valid & !tx_ready; a rewind may change tx_frame.
REQ-028 State machine, encoded from pointers: IDLE (base == nxt), SEND (snd != nxt), WAIT (snd == nxt != base). A timeout moves WAIT or SEND to SEND.
REQ-029 Pointer wrap 2**SEQ_W-1 -> 0 SHALL be seamless; all comparisons use modular differences.

Reset
REQ-030 While rst = 1 at a clock edge: all pointers, timer, retx_count and win_count = 0; tx_valid = 0; tx_frame = 0; in_ready = 1.
REQ-031 Buffer contents are not reset.
REQ-032 Reset during an operation SHALL discard all buffered frames and is visible one edge after assertion.

Verification
REQ-033 Reset: assert rst 2 cycles -> tx_valid = 0, tx_frame = 0, in_ready = 1, win_count = 0, retx_count = 0.
REQ-034 Single frame: push 8'hA5 with tx_ready = 1 -> next cycle tx_frame = 15'h0A5B; then ack_seq = 0 -> win_count = 0, IDLE.
REQ-035 Window full: push 5 payloads, no acks -> in_ready = 0 after the 4th accept; 5th payload held off; win_count = 4.
REQ-036 Go-back: send seq 0..2, ack_seq = 0, then no ack -> TIMEOUT cycles later retransmits seq 1 then seq 2; retx_count = 1.
REQ-037 Ack filtering: ack_seq = 5 while hi = 2 -> ignored. Valid ack in the timeout cycle -> base advances; retx_count is unchanged.
REQ-038 Wrap: 10 frames, each acked promptly -> sequence numbers 0..7,0,1 in order; win_count returns to 0.

Source files
------------

// File: rtl/gbn_arq_tx.sv
// Go-Back-N ARQ transmitter: buffers up to WIN payloads, frames them with a CRC-4,
// and rewinds to the oldest unacknowledged frame on a retransmit timeout.
module gbn_arq_tx #(
    parameter int DW      = 8,
    parameter int SEQ_W   = 3,
    parameter int WIN     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DW-1:0]             in_data,
    output logic                      in_ready,
    output logic                      tx_valid,
    output logic [SEQ_W+DW+3:0]       tx_frame,
    input  logic                      tx_ready,
    input  logic                      ack_valid,
    input  logic [SEQ_W-1:0]          ack_seq,
    output logic [$clog2(WIN+1)-1:0]  win_count,
    output logic [7:0]                retx_count
);

    localparam int AW = $clog2(WIN);
    localparam int CW = $clog2(WIN+1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    logic [SEQ_W-1:0] base, snd, nxt, hi;
    logic [TW-1:0]    timer;
    logic [DW-1:0]    buffer [WIN];

    state_t           state;
    logic [SEQ_W-1:0] occupancy, ack_off, hi_off, snd_inc, snd_step, new_base;
    logic [DW-1:0]    cur_data;
    logic             accept, tx_hs, ack_ok, timeout, snd_behind, hi_grows;

    // x^4 + x + 1, MSB first, zero init, no reflection or final XOR.
    function automatic logic [3:0] crc4(input logic [DW-1:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    always_comb begin
        state = IDLE;
        if (snd != nxt)
            state = SEND;
        else if (nxt != base)
            state = WAIT;
    end

    // All window tests use modular offsets from base so pointer wrap is invisible.
    always_comb begin
        occupancy  = nxt - base;
        win_count  = occupancy[CW-1:0];
        in_ready   = (win_count < CW'(WIN));
        accept     = in_valid & in_ready;
        tx_valid   = (state == SEND);
        tx_hs      = tx_valid & tx_ready;
        cur_data   = buffer[snd[AW-1:0]];
        tx_frame   = tx_valid ? {snd, cur_data, crc4(cur_data)} : '0;
        ack_off    = ack_seq - base;
        hi_off     = hi - base;
        ack_ok     = ack_valid && (ack_off < hi_off);
        new_base   = ack_seq + SEQ_W'(1);
        snd_inc    = snd + SEQ_W'(1);
        snd_step   = tx_hs ? snd_inc : snd;
        snd_behind = ((snd_step - base) < (new_base - base));
        hi_grows   = tx_hs && ((snd_inc - base) > hi_off);
        timeout    = (timer == TW'(TIMEOUT - 1)) && (hi != base) && !ack_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            snd        <= '0;
            nxt        <= '0;
            hi         <= '0;
            timer      <= '0;
            retx_count <= '0;
        end else begin
            if (accept)
                nxt <= nxt + SEQ_W'(1);
            if (hi_grows)
                hi <= snd_inc;
            if (ack_ok)
                base <= new_base;

            // A timeout rewinds to the old base even if a frame left this cycle.
            if (timeout)
                snd <= base;
            else if (ack_ok && snd_behind)
                snd <= new_base;
            else
                snd <= snd_step;

            if (ack_ok || timeout || (hi == base))
                timer <= '0;
            else
                timer <= timer + TW'(1);

            if (timeout && (retx_count != 8'hFF))
                retx_count <= retx_count + 8'd1;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept)
            buffer[nxt[AW-1:0]] <= in_data;
    end

endmodule
